// File: rtl/pc_fetch_unit_if.sv
// Bundles the fetch unit's instruction-memory and decode-side signals.
// Valid/ready semantics on both request paths: the producer raises valid and keeps
// the payload stable until it sees ready in the same cycle. The transfer happens on
// the rising clock edge where valid && ready. Ready may depend on valid, but valid
// must not depend on ready.
// The response path is valid-only, with no ready. Memory returns exactly one response
// per accepted request, and never in the same cycle as the acceptance.
interface pc_fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pcplus4;
  logic        if_ready;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_pcplus4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_pcplus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Owns the architectural PC and fetches one instruction at a time (REQ -> WAIT -> HOLD).
// Execute-stage redirects replace the PC; a fetch still in flight is squashed via kill.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       PCTarget,
  input  logic              PCSrc,
  pc_fetch_unit_if.master   bus,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic [31:0] redir_pc;
  logic        redir_pend;
  logic        kill;
  logic        if_valid_q;
  logic [31:0] if_instr_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_pcplus4_q;

  logic [31:0] target;
  logic        req_fire;
  logic        dec_fire;
  logic        unused_target_bits;

  // Redirect targets are word aligned; the adder's low bits carry no information.
  assign target             = {PCTarget[31:2], 2'b00};
  assign unused_target_bits = ^PCTarget[1:0];

  // Gated with rst_n so no request escapes while reset is held.
  assign bus.imem_req_valid = rst_n && (state == ST_REQ);
  assign bus.imem_req_addr  = pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
  assign dec_fire           = if_valid_q && bus.if_ready;

  assign bus.if_valid   = if_valid_q;
  assign bus.if_instr   = if_instr_q;
  assign bus.if_pc      = if_pc_q;
  assign bus.if_pcplus4 = if_pcplus4_q;
  assign dbg_state      = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_REQ;
      pc           <= RESET_PC;
      req_pc       <= RESET_PC;
      redir_pc     <= RESET_PC;
      redir_pend   <= 1'b0;
      kill         <= 1'b0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= NOP;
      if_pc_q      <= RESET_PC;
      if_pcplus4_q <= RESET_PC + 32'd4;
    end else begin
      case (state)
        ST_REQ: begin
          if (req_fire) begin
            req_pc <= pc;
            state  <= ST_WAIT;
            // The accepted fetch is already stale if a redirect is here or pending.
            if (PCSrc) begin
              kill       <= 1'b1;
              pc         <= target;
              redir_pend <= 1'b0;
            end else if (redir_pend) begin
              kill       <= 1'b1;
              pc         <= redir_pc;
              redir_pend <= 1'b0;
            end
          end else if (PCSrc) begin
            // The address is frozen mid-handshake, so park the target.
            redir_pend <= 1'b1;
            redir_pc   <= target;
          end
        end

        ST_WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (PCSrc) begin
              pc <= target;
            end
            if (kill || PCSrc) begin
              kill  <= 1'b0;
              state <= ST_REQ;
            end else begin
              if_valid_q   <= 1'b1;
              if_instr_q   <= bus.imem_rsp_data;
              if_pc_q      <= req_pc;
              if_pcplus4_q <= req_pc + 32'd4;
              state        <= ST_HOLD;
            end
          end else if (PCSrc) begin
            kill <= 1'b1;
            pc   <= target;
          end
        end

        ST_HOLD: begin
          // A redirect beats a simultaneous decode handshake.
          if (PCSrc) begin
            if_valid_q <= 1'b0;
            pc         <= target;
            state      <= ST_REQ;
          end else if (dec_fire) begin
            if_valid_q <= 1'b0;
            pc         <= if_pcplus4_q;
            state      <= ST_REQ;
          end
        end

        default: begin
          state <= ST_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, backpressure, redirects in each
// state, and address wrap plus async reset on a second instance.
module tb_pc_fetch_unit;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [31:0] SEQ_INSTR [3] = '{32'h00A0_0093, 32'h0010_8113, 32'h0020_0193};
  localparam logic [31:0] SEQ_PC    [3] = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
  localparam logic [31:0] SEQ_PC4   [3] = '{32'h0000_0004, 32'h0000_0008, 32'h0000_000C};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst1_n;
  logic [31:0] pctarget;
  logic        pcsrc;
  logic [31:0] pctarget1;
  logic        pcsrc1;
  logic [1:0]  dbg0;
  logic [1:0]  dbg1;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit_if bus0 ();
  pc_fetch_unit_if bus1 ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .PCTarget(pctarget), .PCSrc(pcsrc), .bus(bus0), .dbg_state(dbg0)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst_n(rst1_n), .PCTarget(pctarget1), .PCSrc(pcsrc1), .bus(bus1), .dbg_state(dbg1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raises ready until the request is seen, then lets one edge accept it.
  task automatic accept_req(output logic [31:0] addr, output bit ok);
    ok = 1'b0;
    addr = 32'hxxxx_xxxx;
    bus0.imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus0.imem_req_valid) begin
        addr = bus0.imem_req_addr;
        ok = 1'b1;
      end
      step();
    end
    bus0.imem_req_ready = 1'b0;
  endtask

  task automatic send_rsp(input logic [31:0] data);
    bus0.imem_rsp_valid = 1'b1;
    bus0.imem_rsp_data  = data;
    step();
    bus0.imem_rsp_valid = 1'b0;
  endtask

  task automatic take();
    bus0.if_ready = 1'b1;
    step();
    bus0.if_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (bus0.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", bus0.imem_req_valid); end
    checks++; if (bus0.if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid got %b exp 0", bus0.if_valid); end
    checks++; if (bus0.if_instr !== 32'h0000_0013) begin errors++; $display("FAIL rst_if_instr got %h exp 00000013", bus0.if_instr); end
    checks++; if (bus0.if_pc !== 32'h0000_0000) begin errors++; $display("FAIL rst_if_pc got %h exp 00000000", bus0.if_pc); end
    checks++; if (bus0.if_pcplus4 !== 32'h0000_0004) begin errors++; $display("FAIL rst_if_pcplus4 got %h exp 00000004", bus0.if_pcplus4); end
    checks++; if (dbg0 !== S_REQ) begin errors++; $display("FAIL rst_state got %0d exp %0d", dbg0, S_REQ); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus0.imem_req_valid !== 1'b1) begin errors++; $display("FAIL rel_req_valid got %b exp 1", bus0.imem_req_valid); end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      accept_req(a, ok);
      checks++; if (!ok) begin errors++; $display("FAIL seq%0d_req timeout got none exp request", i); end
      checks++; if (a !== SEQ_PC[i]) begin errors++; $display("FAIL seq%0d_addr got %h exp %h", i, a, SEQ_PC[i]); end
      checks++; if (dbg0 !== S_WAIT) begin errors++; $display("FAIL seq%0d_state got %0d exp %0d", i, dbg0, S_WAIT); end
      send_rsp(SEQ_INSTR[i]);
      checks++; if (bus0.if_valid !== 1'b1) begin errors++; $display("FAIL seq%0d_if_valid got %b exp 1", i, bus0.if_valid); end
      checks++; if (bus0.if_instr !== SEQ_INSTR[i]) begin errors++; $display("FAIL seq%0d_instr got %h exp %h", i, bus0.if_instr, SEQ_INSTR[i]); end
      checks++; if (bus0.if_pc !== SEQ_PC[i]) begin errors++; $display("FAIL seq%0d_pc got %h exp %h", i, bus0.if_pc, SEQ_PC[i]); end
      checks++; if (bus0.if_pcplus4 !== SEQ_PC4[i]) begin errors++; $display("FAIL seq%0d_pc4 got %h exp %h", i, bus0.if_pcplus4, SEQ_PC4[i]); end
      take();
      checks++; if (bus0.if_valid !== 1'b0) begin errors++; $display("FAIL seq%0d_drop got %b exp 0", i, bus0.if_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    bit ok;
    accept_req(a, ok);
    checks++; if (a !== 32'h0000_000C) begin errors++; $display("FAIL bp_addr got %h exp 0000000C", a); end
    send_rsp(32'hDEAD_BEEF);
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus0.if_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_valid got %b exp 1", k, bus0.if_valid); end
      checks++; if (bus0.if_instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp%0d_instr got %h exp DEADBEEF", k, bus0.if_instr); end
      checks++; if (bus0.if_pc !== 32'h0000_000C) begin errors++; $display("FAIL bp%0d_pc got %h exp 0000000C", k, bus0.if_pc); end
      checks++; if (bus0.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp%0d_no_req got %b exp 0", k, bus0.imem_req_valid); end
      step();
    end
    take();
    accept_req(a, ok);
    checks++; if (a !== 32'h0000_0010) begin errors++; $display("FAIL bp_next_addr got %h exp 00000010", a); end
  endtask

  task automatic test_redirect_wait();
    logic [31:0] a;
    bit ok;
    pcsrc = 1'b1;
    pctarget = 32'h0000_0100;
    step();
    pcsrc = 1'b0;
    checks++; if (dbg0 !== S_WAIT) begin errors++; $display("FAIL rw_state got %0d exp %0d", dbg0, S_WAIT); end
    step();
    send_rsp(32'hBAD0_0010);
    checks++; if (bus0.if_valid !== 1'b0) begin errors++; $display("FAIL rw_squash got %b exp 0", bus0.if_valid); end
    checks++; if (dbg0 !== S_REQ) begin errors++; $display("FAIL rw_back_req got %0d exp %0d", dbg0, S_REQ); end
    accept_req(a, ok);
    checks++; if (a !== 32'h0000_0100) begin errors++; $display("FAIL rw_addr got %h exp 00000100", a); end
    send_rsp(32'h0000_0513);
    checks++; if (bus0.if_pc !== 32'h0000_0100) begin errors++; $display("FAIL rw_pc got %h exp 00000100", bus0.if_pc); end
    checks++; if (bus0.if_pcplus4 !== 32'h0000_0104) begin errors++; $display("FAIL rw_pc4 got %h exp 00000104", bus0.if_pcplus4); end
    checks++; if (bus0.if_instr !== 32'h0000_0513) begin errors++; $display("FAIL rw_instr got %h exp 00000513", bus0.if_instr); end
    take();
  endtask

  task automatic test_redirect_stall();
    logic [31:0] a;
    bit ok;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      accept_req(a, ok);
      send_rsp(32'h0000_0013);
      take();
    end
    checks++; if (bus0.imem_req_addr !== 32'h0000_0008) begin errors++; $display("FAIL rs_start_addr got %h exp 00000008", bus0.imem_req_addr); end
    pcsrc = 1'b1;
    pctarget = 32'h0000_0040;
    step();
    pcsrc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus0.imem_req_valid !== 1'b1 || bus0.imem_req_addr !== 32'h0000_0008) begin errors++; $display("FAIL rs%0d_stable got %b/%h exp 1/00000008", k, bus0.imem_req_valid, bus0.imem_req_addr); end
      if (k < 2) step();
    end
    accept_req(a, ok);
    checks++; if (a !== 32'h0000_0008) begin errors++; $display("FAIL rs_accept_addr got %h exp 00000008", a); end
    send_rsp(32'hBAD0_0008);
    checks++; if (bus0.if_valid !== 1'b0) begin errors++; $display("FAIL rs_squash got %b exp 0", bus0.if_valid); end
    accept_req(a, ok);
    checks++; if (a !== 32'h0000_0040) begin errors++; $display("FAIL rs_next_addr got %h exp 00000040", a); end
    send_rsp(32'h0040_0093);
    checks++; if (bus0.if_pc !== 32'h0000_0040) begin errors++; $display("FAIL rs_pc got %h exp 00000040", bus0.if_pc); end
  endtask

  task automatic test_redirect_hold();
    logic [31:0] a;
    bit ok;
    checks++; if (dbg0 !== S_HOLD) begin errors++; $display("FAIL rh_pre_state got %0d exp %0d", dbg0, S_HOLD); end
    bus0.if_ready = 1'b1;
    pcsrc = 1'b1;
    pctarget = 32'h0000_0203;
    step();
    bus0.if_ready = 1'b0;
    pcsrc = 1'b0;
    checks++; if (bus0.if_valid !== 1'b0) begin errors++; $display("FAIL rh_drop got %b exp 0", bus0.if_valid); end
    checks++; if (dbg0 !== S_REQ) begin errors++; $display("FAIL rh_state got %0d exp %0d", dbg0, S_REQ); end
    accept_req(a, ok);
    checks++; if (a !== 32'h0000_0200) begin errors++; $display("FAIL rh_addr got %h exp 00000200", a); end
    send_rsp(32'h0000_0293);
    checks++; if (bus0.if_pcplus4 !== 32'h0000_0204) begin errors++; $display("FAIL rh_pc4 got %h exp 00000204", bus0.if_pcplus4); end
    take();
  endtask

  task automatic test_wrap_reset();
    rst1_n = 1'b1;
    #1;
    checks++; if (bus1.imem_req_valid !== 1'b1 || bus1.imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_first got %b/%h exp 1/FFFFFFFC", bus1.imem_req_valid, bus1.imem_req_addr); end
    bus1.imem_req_ready = 1'b1;
    step();
    bus1.imem_req_ready = 1'b0;
    bus1.imem_rsp_valid = 1'b1;
    bus1.imem_rsp_data  = 32'h1234_5678;
    step();
    bus1.imem_rsp_valid = 1'b0;
    checks++; if (bus1.if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_pc got %h exp FFFFFFFC", bus1.if_pc); end
    checks++; if (bus1.if_pcplus4 !== 32'h0000_0000) begin errors++; $display("FAIL wr_pc4 got %h exp 00000000", bus1.if_pcplus4); end
    bus1.if_ready = 1'b1;
    step();
    bus1.if_ready = 1'b0;
    checks++; if (bus1.imem_req_valid !== 1'b1 || bus1.imem_req_addr !== 32'h0000_0000) begin errors++; $display("FAIL wr_second got %b/%h exp 1/00000000", bus1.imem_req_valid, bus1.imem_req_addr); end
    bus1.imem_req_ready = 1'b1;
    step();
    bus1.imem_req_ready = 1'b0;
    checks++; if (dbg1 !== S_WAIT) begin errors++; $display("FAIL wr_wait got %0d exp %0d", dbg1, S_WAIT); end
    #2;
    rst1_n = 1'b0;
    #1;
    checks++; if (bus1.imem_req_valid !== 1'b0) begin errors++; $display("FAIL ar_req_valid got %b exp 0", bus1.imem_req_valid); end
    checks++; if (bus1.if_instr !== 32'h0000_0013) begin errors++; $display("FAIL ar_instr got %h exp 00000013", bus1.if_instr); end
    checks++; if (bus1.if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL ar_pc got %h exp FFFFFFFC", bus1.if_pc); end
    checks++; if (bus1.if_pcplus4 !== 32'h0000_0000) begin errors++; $display("FAIL ar_pc4 got %h exp 00000000", bus1.if_pcplus4); end
    checks++; if (dbg1 !== S_REQ) begin errors++; $display("FAIL ar_state got %0d exp %0d", dbg1, S_REQ); end
    step();
    rst1_n = 1'b1;
    bus1.imem_rsp_valid = 1'b1;
    bus1.imem_rsp_data  = 32'hBAD0_BAD0;
    step();
    bus1.imem_rsp_valid = 1'b0;
    checks++; if (bus1.if_valid !== 1'b0) begin errors++; $display("FAIL ar_stray_rsp got %b exp 0", bus1.if_valid); end
    checks++; if (bus1.imem_req_valid !== 1'b1 || bus1.imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL ar_first got %b/%h exp 1/FFFFFFFC", bus1.imem_req_valid, bus1.imem_req_addr); end
  endtask

  initial begin
    rst_n = 1'b0;
    rst1_n = 1'b0;
    pcsrc = 1'b0;
    pctarget = 32'h0;
    pcsrc1 = 1'b0;
    pctarget1 = 32'h0;
    bus0.imem_req_ready = 1'b0;
    bus0.imem_rsp_valid = 1'b0;
    bus0.imem_rsp_data  = 32'h0;
    bus0.if_ready       = 1'b0;
    bus1.imem_req_ready = 1'b0;
    bus1.imem_rsp_valid = 1'b0;
    bus1.imem_rsp_data  = 32'h0;
    bus1.if_ready       = 1'b0;

    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_stall();
    test_redirect_hold();
    test_wrap_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
